// File: rtl/ctrl_port.sv
// Responder for the $4016/$4017 controller ports: OUT latch, two joypad shift registers, read-triggered shifting.
// Define CTRL_PORT_SYNC_EN to pass the pad inputs through 2-flop synchronizers before reload.
module ctrl_port #(
    parameter logic [2:0] RD_OPEN_BUS = 3'b010
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic [15:0] I_addr,
    input  logic [7:0]  I_wr_data,
    input  logic        I_rdwr,
    input  logic        I_phy2,
    input  logic [7:0]  I_pad0,
    input  logic [7:0]  I_pad1,
    output logic [7:0]  O_rd_data,
    output logic        O_hit,
    output logic [2:0]  O_out
);

    localparam logic [15:0] ADDR_PORT0 = 16'h4016;
    localparam logic [15:0] ADDR_PORT1 = 16'h4017;

    logic       sel16;
    logic       sel17;
    logic       wr16;
    logic       rd16;
    logic       rd17;
    logic [7:0] pad0_q;
    logic [7:0] pad1_q;
    logic [2:0] out_q;
    logic [2:0] out_d;
    logic [7:0] sr0_q;
    logic [7:0] sr0_d;
    logic [7:0] sr1_q;
    logic [7:0] sr1_d;
    logic       unused_wr_bits;

    assign sel16 = (I_addr == ADDR_PORT0);
    assign sel17 = (I_addr == ADDR_PORT1);

    // $4017 writes belong to the APU frame counter, so only $4016 decodes a write.
    assign wr16 = I_phy2 & ~I_rdwr & sel16;
    assign rd16 = I_phy2 &  I_rdwr & sel16;
    assign rd17 = I_phy2 &  I_rdwr & sel17;

    assign unused_wr_bits = ^I_wr_data[7:3];

`ifdef CTRL_PORT_SYNC_EN
    logic [7:0] pad0_meta_q;
    logic [7:0] pad1_meta_q;

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            pad0_meta_q <= 8'h00;
            pad1_meta_q <= 8'h00;
            pad0_q      <= 8'h00;
            pad1_q      <= 8'h00;
        end else begin
            pad0_meta_q <= I_pad0;
            pad1_meta_q <= I_pad1;
            pad0_q      <= pad0_meta_q;
            pad1_q      <= pad1_meta_q;
        end
    end
`else
    assign pad0_q = I_pad0;
    assign pad1_q = I_pad1;
`endif

    // Reload is keyed on the strobe already latched, so a 1->0 write still reloads in its own cycle.
    always_comb begin
        out_d = out_q;
        sr0_d = sr0_q;
        sr1_d = sr1_q;
        if (wr16) begin
            out_d = I_wr_data[2:0];
        end
        if (out_q[0]) begin
            sr0_d = pad0_q;
            sr1_d = pad1_q;
        end else begin
            if (rd16) begin
                sr0_d = {1'b1, sr0_q[7:1]};
            end
            if (rd17) begin
                sr1_d = {1'b1, sr1_q[7:1]};
            end
        end
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            out_q <= 3'b000;
            sr0_q <= 8'hFF;
            sr1_q <= 8'hFF;
        end else begin
            out_q <= out_d;
            sr0_q <= sr0_d;
            sr1_q <= sr1_d;
        end
    end

    assign O_out     = out_q;
    assign O_hit     = (sel16 | sel17) & I_rdwr;
    assign O_rd_data = O_hit ? {RD_OPEN_BUS, 4'b0000, (I_addr[0] ? sr1_q[0] : sr0_q[0])}
                             : 8'h00;

endmodule
